// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline hazard/stall/flush sequencer:
//   FSM state encodings, the MIPS opcodes the controller looks at, and
//   the width of the post-branch flush counter.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // FLUSH_CYCLES is limited to 1..3, so the remaining-squash count fits in 2 bits.
  localparam int FCNT_WIDTH = 2;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// pipeline_ctrl_hazard_detect
//   Combinational load-use hazard compare between the instruction in ID
//   and a load sitting in EX.
// Ports
//   opcode       in  OPCODE_WIDTH  opcode of the ID instruction
//   rs, rt       in  AWIDTH        source registers of the ID instruction
//   ex_memtoreg  in  1             EX instruction is a load
//   ex_rt        in  AWIDTH        load destination register
//   lu           out 1             ID must wait one cycle for the load data
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [AWIDTH-1:0]       rs,
  input  logic [AWIDTH-1:0]       rt,
  input  logic                    ex_memtoreg,
  input  logic [AWIDTH-1:0]       ex_rt,
  output logic                    lu
);

  logic uses_rt;

  // Only these formats read rt as a source; for I-type ALU ops and loads rt is a destination.
  always_comb begin
    uses_rt = (opcode == OPCODE_WIDTH'(OP_RTYPE)) |
              (opcode == OPCODE_WIDTH'(OP_BEQ))   |
              (opcode == OPCODE_WIDTH'(OP_BNE))   |
              (opcode == OPCODE_WIDTH'(OP_SW));
  end

  // $zero never creates a dependency.
  always_comb begin
    lu = ex_memtoreg & (ex_rt != '0) &
         ((ex_rt == rs) | ((ex_rt == rt) & uses_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard/stall/flush sequencer for the 5-stage MIPS pipeline (ID stage).
//   Drives PC / IF/ID / ID/EX enables and flushes plus the decoder chip-enable.
//   Outputs are combinational from the registered state and current inputs.
// Ports
//   p_i_clk, p_i_rst (async, active-low), p_i_ce (0 = freeze)
//   p_i_id_opcode/rs/rt      ID instruction fields
//   p_i_ex_memtoreg, p_i_ex_rt  load in EX
//   p_i_branch_taken         branch resolved taken in EX
//   p_i_mem_req, p_i_mem_ack data-memory handshake from MEM
//   p_o_pc_we, p_o_ifid_we, p_o_ifid_flush, p_o_idex_flush, p_o_dec_ce, p_o_state
// Configuration
//   `PCTRL_PERF_EN adds p_i_perf_clr, p_o_stall_cnt, p_o_flush_cnt (saturating).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int OPCODE_WIDTH = 6,
  parameter int FLUSH_CYCLES = 1
`ifdef PCTRL_PERF_EN
  ,
  parameter int CNT_WIDTH    = 16
`endif
) (
  input  logic                    p_i_clk,
  input  logic                    p_i_rst,
  input  logic                    p_i_ce,
  input  logic [OPCODE_WIDTH-1:0] p_i_id_opcode,
  input  logic [AWIDTH-1:0]       p_i_id_rs,
  input  logic [AWIDTH-1:0]       p_i_id_rt,
  input  logic                    p_i_ex_memtoreg,
  input  logic [AWIDTH-1:0]       p_i_ex_rt,
  input  logic                    p_i_branch_taken,
  input  logic                    p_i_mem_req,
  input  logic                    p_i_mem_ack,
  output logic                    p_o_pc_we,
  output logic                    p_o_ifid_we,
  output logic                    p_o_ifid_flush,
  output logic                    p_o_idex_flush,
  output logic                    p_o_dec_ce,
`ifdef PCTRL_PERF_EN
  input  logic                    p_i_perf_clr,
  output logic [CNT_WIDTH-1:0]    p_o_stall_cnt,
  output logic [CNT_WIDTH-1:0]    p_o_flush_cnt,
`endif
  output logic [1:0]              p_o_state
);

  localparam logic [FCNT_WIDTH-1:0] FLUSH_LOAD = FCNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t                state_q, state_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  lu, mem_stall;
  logic                  pc_we, ifid_we, ifid_flush, idex_flush, dec_ce;

  pipeline_ctrl_hazard_detect #(
    .AWIDTH       (AWIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_hazard (
    .opcode      (p_i_id_opcode),
    .rs          (p_i_id_rs),
    .rt          (p_i_id_rt),
    .ex_memtoreg (p_i_ex_memtoreg),
    .ex_rt       (p_i_ex_rt),
    .lu          (lu)
  );

  assign mem_stall = p_i_mem_req & ~p_i_mem_ack;

  // State and flush counter register.
  always_ff @(posedge p_i_clk or negedge p_i_rst) begin
    if (!p_i_rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state and control decode; priority order inside RUN/LDUSE/MEMWAIT
  // is memory stall, taken branch, load-use, JAL, normal advance.
  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    dec_ce     = 1'b0;
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    if (p_i_ce) begin
      case (state_q)
        ST_FLUSH: begin
          pc_we      = 1'b1;
          ifid_flush = 1'b1;
          // A data-memory wait pauses the squash window rather than consuming it.
          if (!mem_stall) begin
            if (fcnt_q <= FCNT_WIDTH'(1)) begin
              fcnt_d  = '0;
              state_d = ST_RUN;
            end else begin
              fcnt_d = fcnt_q - FCNT_WIDTH'(1);
            end
          end
        end
        default: begin
          if (mem_stall) begin
            state_d = ST_MEMWAIT;
          end else if (p_i_branch_taken) begin
            pc_we      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              fcnt_d  = FLUSH_LOAD;
            end else begin
              state_d = ST_RUN;
            end
          // The bubble inserted on the previous cycle already resolved the hazard.
          end else if (lu && (state_q != ST_LDUSE)) begin
            idex_flush = 1'b1;
            state_d    = ST_LDUSE;
          end else if (p_i_id_opcode == OPCODE_WIDTH'(OP_JAL)) begin
            pc_we      = 1'b1;
            ifid_flush = 1'b1;
            state_d    = ST_RUN;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            dec_ce  = 1'b1;
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  // Reset forces both stages to hold NOPs and the front end to stay still.
  always_comb begin
    p_o_pc_we      = p_i_rst & pc_we;
    p_o_ifid_we    = p_i_rst & ifid_we;
    p_o_ifid_flush = ~p_i_rst | ifid_flush;
    p_o_idex_flush = ~p_i_rst | idex_flush;
    p_o_dec_ce     = p_i_rst & dec_ce;
    p_o_state      = state_q;
  end

`ifdef PCTRL_PERF_EN
  // Saturating stall/flush counters with synchronous clear.
  always_ff @(posedge p_i_clk or negedge p_i_rst) begin
    if (!p_i_rst) begin
      p_o_stall_cnt <= '0;
      p_o_flush_cnt <= '0;
    end else if (p_i_perf_clr) begin
      p_o_stall_cnt <= '0;
      p_o_flush_cnt <= '0;
    end else begin
      if (p_i_ce && !p_o_pc_we && (p_o_stall_cnt != '1))
        p_o_stall_cnt <= p_o_stall_cnt + CNT_WIDTH'(1);
      if (p_o_ifid_flush && (p_o_flush_cnt != '1))
        p_o_flush_cnt <= p_o_flush_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl built with FLUSH_CYCLES=2.
//   Each step drives one cycle of inputs and pushes the expected output
//   vector {pc_we, ifid_we, ifid_flush, idex_flush, dec_ce, state}.
module tb_pipeline_ctrl;

  logic       p_i_clk = 1'b0;
  logic       p_i_rst;
  logic       p_i_ce;
  logic [5:0] p_i_id_opcode;
  logic [4:0] p_i_id_rs, p_i_id_rt, p_i_ex_rt;
  logic       p_i_ex_memtoreg, p_i_branch_taken, p_i_mem_req, p_i_mem_ack;
  logic       p_o_pc_we, p_o_ifid_we, p_o_ifid_flush, p_o_idex_flush, p_o_dec_ce;
  logic [1:0] p_o_state;
`ifdef PCTRL_PERF_EN
  logic        p_i_perf_clr;
  logic [15:0] p_o_stall_cnt, p_o_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rst_n;
    logic       ce;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mtr;
    logic [4:0] ex_rt;
    logic       br;
    logic       req;
    logic       ack;
    logic       clr;
  } stim_t;

  typedef struct {
    logic [6:0] want;
    string      name;
  } sb_t;

  localparam stim_t IDLE = '{rst_n: 1'b1, ce: 1'b1, op: 6'h00, rs: 5'd1, rt: 5'd2,
                             mtr: 1'b0, ex_rt: 5'd0, br: 1'b0, req: 1'b0, ack: 1'b0, clr: 1'b0};

  localparam logic [6:0] E_RST      = 7'b0011000;
  localparam logic [6:0] E_RUN      = 7'b1100100;
  localparam logic [6:0] E_LU       = 7'b0001000;
  localparam logic [6:0] E_REL_LU   = 7'b1100101;
  localparam logic [6:0] E_BR       = 7'b1011000;
  localparam logic [6:0] E_BR_LU    = 7'b1011001;
  localparam logic [6:0] E_FLUSH    = 7'b1010011;
  localparam logic [6:0] E_JAL      = 7'b1010000;
  localparam logic [6:0] E_FRZ_RUN  = 7'b0000000;
  localparam logic [6:0] E_FRZ_MW   = 7'b0000010;
  localparam logic [6:0] E_FRZ_LU   = 7'b0000001;
  localparam logic [6:0] E_REL_MW   = 7'b1100110;

  sb_t        sb[$];
  stim_t      plan_s[$];
  logic [6:0] plan_e[$];
  string      plan_n[$];
  logic [6:0] obs;

  assign obs = {p_o_pc_we, p_o_ifid_we, p_o_ifid_flush, p_o_idex_flush, p_o_dec_ce, p_o_state};

  pipeline_ctrl #(
    .AWIDTH       (5),
    .OPCODE_WIDTH (6),
    .FLUSH_CYCLES (2)
  ) dut (
    .p_i_clk          (p_i_clk),
    .p_i_rst          (p_i_rst),
    .p_i_ce           (p_i_ce),
    .p_i_id_opcode    (p_i_id_opcode),
    .p_i_id_rs        (p_i_id_rs),
    .p_i_id_rt        (p_i_id_rt),
    .p_i_ex_memtoreg  (p_i_ex_memtoreg),
    .p_i_ex_rt        (p_i_ex_rt),
    .p_i_branch_taken (p_i_branch_taken),
    .p_i_mem_req      (p_i_mem_req),
    .p_i_mem_ack      (p_i_mem_ack),
    .p_o_pc_we        (p_o_pc_we),
    .p_o_ifid_we      (p_o_ifid_we),
    .p_o_ifid_flush   (p_o_ifid_flush),
    .p_o_idex_flush   (p_o_idex_flush),
    .p_o_dec_ce       (p_o_dec_ce),
`ifdef PCTRL_PERF_EN
    .p_i_perf_clr     (p_i_perf_clr),
    .p_o_stall_cnt    (p_o_stall_cnt),
    .p_o_flush_cnt    (p_o_flush_cnt),
`endif
    .p_o_state        (p_o_state)
  );

  always #5 p_i_clk = ~p_i_clk;

  task automatic apply_inputs(input stim_t s);
    p_i_rst          = s.rst_n;
    p_i_ce           = s.ce;
    p_i_id_opcode    = s.op;
    p_i_id_rs        = s.rs;
    p_i_id_rt        = s.rt;
    p_i_ex_memtoreg  = s.mtr;
    p_i_ex_rt        = s.ex_rt;
    p_i_branch_taken = s.br;
    p_i_mem_req      = s.req;
    p_i_mem_ack      = s.ack;
`ifdef PCTRL_PERF_EN
    p_i_perf_clr     = s.clr;
`endif
  endtask

  // Drive one cycle just after the rising edge, record the expectation,
  // and return at the mid-cycle sample point.
  task automatic step(input stim_t s, input logic [6:0] want, input string name);
    @(posedge p_i_clk);
    #1;
    apply_inputs(s);
    sb.push_back('{want, name});
    #3;
  endtask

  task automatic plan(input stim_t s, input logic [6:0] want, input string name);
    plan_s.push_back(s);
    plan_e.push_back(want);
    plan_n.push_back(name);
  endtask

  task automatic plan_clear();
    plan_s.delete();
    plan_e.delete();
    plan_n.delete();
  endtask

  task automatic test_reset();
    stim_t s;
    sb_t   e;
    plan_clear();
    s = IDLE; s.rst_n = 1'b0;            plan(s, E_RST, "rst_idle");
    s.ce = 1'b0; s.br = 1'b1;            plan(s, E_RST, "rst_over_ce0");
    s = IDLE;                            plan(s, E_RUN, "rst_release");
    plan(IDLE, E_RUN, "run_idle");
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_s[i], plan_e[i], plan_n[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e.want) begin
        bad++;
        $display("[TB] FAIL %s: got %b want %b", e.name, obs, e.want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    sb_t   e;
    plan_clear();
    s = IDLE; s.mtr = 1'b1; s.ex_rt = 5'd5; s.op = 6'h00; s.rs = 5'd5;
    plan(s, E_LU, "lu_stall");
    plan(s, E_REL_LU, "lu_release");
    plan(s, E_LU, "lu_again");
    plan(IDLE, E_REL_LU, "lu_release_idle");
    plan(IDLE, E_RUN, "lu_back_run");
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_s[i], plan_e[i], plan_n[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e.want) begin
        bad++;
        $display("[TB] FAIL %s: got %b want %b", e.name, obs, e.want);
      end
    end
  endtask

  task automatic test_hazard_cases();
    stim_t s;
    sb_t   e;
    plan_clear();
    s = IDLE; s.mtr = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0; s.rt = 5'd0;
    plan(s, E_RUN, "zero_reg");
    s = IDLE; s.mtr = 1'b1; s.ex_rt = 5'd7; s.rs = 5'd3; s.rt = 5'd7;
    s.op = 6'h2B; plan(s, E_LU, "sw_rt");
    plan(IDLE, E_REL_LU, "sw_release");
    s.op = 6'h08; plan(s, E_RUN, "addi_rt");
    s.op = 6'h23; plan(s, E_RUN, "lw_rt");
    s.op = 6'h04; plan(s, E_LU, "beq_rt");
    plan(IDLE, E_REL_LU, "beq_release");
    s.op = 6'h08; s.rs = 5'd7; s.rt = 5'd1;
    plan(s, E_LU, "addi_rs");
    plan(IDLE, E_REL_LU, "addi_release");
    s = IDLE; s.op = 6'h00; s.rs = 5'd5; s.ex_rt = 5'd5;
    plan(s, E_RUN, "not_load");
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_s[i], plan_e[i], plan_n[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e.want) begin
        bad++;
        $display("[TB] FAIL %s: got %b want %b", e.name, obs, e.want);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s, lu_s;
    sb_t   e;
    plan_clear();
    lu_s = IDLE; lu_s.mtr = 1'b1; lu_s.ex_rt = 5'd5; lu_s.rs = 5'd5;
    s = lu_s; s.br = 1'b1;               plan(s, E_BR, "br_over_lu");
    plan(IDLE, E_FLUSH, "flush_state");
    plan(IDLE, E_RUN, "flush_done");
    s = IDLE; s.br = 1'b1;               plan(s, E_BR, "br_plain");
    s = IDLE; s.req = 1'b1;              plan(s, E_FLUSH, "flush_memwait");
    plan(IDLE, E_FLUSH, "flush_resume");
    plan(IDLE, E_RUN, "flush_done2");
    s = IDLE; s.br = 1'b1; s.req = 1'b1; plan(s, E_FRZ_RUN, "mem_over_br");
    s = IDLE; s.req = 1'b1; s.ack = 1'b1; plan(s, E_REL_MW, "mw_release");
    plan(lu_s, E_LU, "lu_before_br");
    s = IDLE; s.br = 1'b1;               plan(s, E_BR_LU, "br_in_lduse");
    plan(IDLE, E_FLUSH, "flush_after_lduse");
    plan(IDLE, E_RUN, "flush_done3");
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_s[i], plan_e[i], plan_n[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e.want) begin
        bad++;
        $display("[TB] FAIL %s: got %b want %b", e.name, obs, e.want);
      end
    end
  endtask

  task automatic test_memwait();
    stim_t s, st;
    sb_t   e;
    plan_clear();
    s = IDLE; s.clr = 1'b1;              plan(s, E_RUN, "mw_pre");
    st = IDLE; st.req = 1'b1;
    plan(st, E_FRZ_RUN, "mw_enter");
    plan(st, E_FRZ_MW, "mw_hold1");
    plan(st, E_FRZ_MW, "mw_hold2");
    s = st; s.ack = 1'b1;                plan(s, E_REL_MW, "mw_ack");
    plan(IDLE, E_RUN, "mw_back_run");
    plan(st, E_FRZ_RUN, "mw_enter2");
    plan(st, E_FRZ_MW, "mw_hold3");
    s = st; s.rst_n = 1'b0;              plan(s, E_RST, "mw_reset");
    plan(IDLE, E_RUN, "mw_after_reset");
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_s[i], plan_e[i], plan_n[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e.want) begin
        bad++;
        $display("[TB] FAIL %s: got %b want %b", e.name, obs, e.want);
      end
`ifdef PCTRL_PERF_EN
      if (i == 4) begin
        total++;
        if (p_o_stall_cnt !== 16'd3) begin
          bad++;
          $display("[TB] FAIL stall_cnt: got %0d want 3", p_o_stall_cnt);
        end
      end
`endif
    end
  endtask

  task automatic test_jal_and_freeze();
    stim_t s, lu_s;
    sb_t   e;
    plan_clear();
    // Instruction word 0x0C400000: opcode 0x03, rs 2, rt 0.
    s = IDLE; s.op = 6'h03; s.rs = 5'd2; s.rt = 5'd0;
    plan(s, E_JAL, "jal");
    plan(IDLE, E_RUN, "jal_after");
    s = IDLE; s.req = 1'b1;              plan(s, E_FRZ_RUN, "ce_mw_enter");
    s.ce = 1'b0;                         plan(s, E_FRZ_MW, "ce0_in_mw");
    s = IDLE; s.ce = 1'b0; s.br = 1'b1;  plan(s, E_FRZ_MW, "ce0_br_in_mw");
    s = IDLE; s.req = 1'b1; s.ack = 1'b1; plan(s, E_REL_MW, "ce_mw_release");
    s = IDLE; s.ce = 1'b0; s.br = 1'b1;  plan(s, E_FRZ_RUN, "ce0_br_in_run");
    plan(IDLE, E_RUN, "ce0_no_flush");
    lu_s = IDLE; lu_s.mtr = 1'b1; lu_s.ex_rt = 5'd9; lu_s.rs = 5'd9;
    plan(lu_s, E_LU, "ce_lu");
    s = lu_s; s.ce = 1'b0;               plan(s, E_FRZ_LU, "ce0_in_lduse");
    plan(IDLE, E_REL_LU, "ce_lu_release");
    plan(IDLE, E_RUN, "ce_back_run");
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_s[i], plan_e[i], plan_n[i]);
      e = sb.pop_front();
      total++;
      if (obs !== e.want) begin
        bad++;
        $display("[TB] FAIL %s: got %b want %b", e.name, obs, e.want);
      end
    end
  endtask

  initial begin
    stim_t s;
    s = IDLE;
    s.rst_n = 1'b0;
    apply_inputs(s);
    test_reset();
    test_load_use();
    test_hazard_cases();
    test_branch();
    test_memwait();
    test_jal_and_freeze();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
